// File: rtl/wfm_loader_pkg.sv
// Shared definitions for the dds waveform-table loader: FSM states and the
// table-address width helper also used by the dds block.
package wfm_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } wfm_state_e;

  // Address width for a table of the given depth (minimum of one bit).
  function automatic int unsigned tbl_aw(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wfm_loader.sv
// Streams one frame of samples into the dds waveform table starting at a
// programmable address, checking the frame length against the programmed count.
module wfm_loader
  import wfm_loader_pkg::*;
#(
  parameter  int unsigned DEPTH = 1024,
  parameter  int unsigned OW    = 24,
  localparam int unsigned AW    = tbl_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   load_len,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [OW-1:0] s_data,
  input  logic          s_last,
  output logic          wfm_wea,
  output logic [AW-1:0] wfm_waddr,
  output logic [OW-1:0] wfm_din,
  output logic          busy,
  output logic          done,
  output logic          err_short,
  output logic          err_long,
  output logic          err_len,
  output logic [AW:0]   count
);

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

  wfm_state_e    r_state, w_state_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic [AW:0]   r_rem, w_rem_nxt;
  logic [AW:0]   r_count, w_count_nxt;
  logic          r_s_ready, r_busy;
  logic          r_wea, w_wea_nxt;
  logic [AW-1:0] r_waddr, w_waddr_nxt;
  logic [OW-1:0] r_din, w_din_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err_short, w_err_short_nxt;
  logic          r_err_long, w_err_long_nxt;
  logic          r_err_len, w_err_len_nxt;
  logic          w_accept;

  assign w_accept = s_valid && r_s_ready;

  // State and datapath registers; reset leaves table contents untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_rem       <= '0;
      r_count     <= '0;
      r_s_ready   <= 1'b0;
      r_busy      <= 1'b0;
      r_wea       <= 1'b0;
      r_waddr     <= '0;
      r_din       <= '0;
      r_done      <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      r_err_len   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_rem       <= w_rem_nxt;
      r_count     <= w_count_nxt;
      r_s_ready   <= (w_state_nxt != ST_IDLE);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_wea       <= w_wea_nxt;
      r_waddr     <= w_waddr_nxt;
      r_din       <= w_din_nxt;
      r_done      <= w_done_nxt;
      r_err_short <= w_err_short_nxt;
      r_err_long  <= w_err_long_nxt;
      r_err_len   <= w_err_len_nxt;
    end
  end

  // Next-state, counters and write-port outputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_rem_nxt       = r_rem;
    w_count_nxt     = r_count;
    w_wea_nxt       = 1'b0;
    w_waddr_nxt     = r_waddr;
    w_din_nxt       = r_din;
    w_done_nxt      = 1'b0;
    w_err_short_nxt = 1'b0;
    w_err_long_nxt  = 1'b0;
    w_err_len_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if ((load_len == '0) || (load_len > LEN_MAX)) begin
            w_err_len_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_LOAD;
            w_addr_nxt  = start_addr;
            w_rem_nxt   = load_len;
            w_count_nxt = '0;
          end
        end
      end

      ST_LOAD: begin
        if (w_accept) begin
          w_wea_nxt   = 1'b1;
          w_waddr_nxt = r_addr;
          w_din_nxt   = s_data;
          // Power-of-two depth: natural overflow wraps DEPTH-1 back to 0.
          w_addr_nxt  = r_addr + AW'(1);
          w_count_nxt = r_count + LEN_ONE;
          w_rem_nxt   = r_rem - LEN_ONE;
          if (r_rem == LEN_ONE) begin
            if (s_last) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_err_long_nxt = 1'b1;
              w_state_nxt    = ST_DRAIN;
            end
          end else if (s_last) begin
            w_err_short_nxt = 1'b1;
            w_state_nxt     = ST_IDLE;
          end
        end
      end

      ST_DRAIN: begin
        if (w_accept && s_last) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign s_ready   = r_s_ready;
  assign busy      = r_busy;
  assign wfm_wea   = r_wea;
  assign wfm_waddr = r_waddr;
  assign wfm_din   = r_din;
  assign done      = r_done;
  assign err_short = r_err_short;
  assign err_long  = r_err_long;
  assign err_len   = r_err_len;
  assign count     = r_count;

endmodule

// File: tb/tb_wfm_loader.sv
// Scoreboard bench for wfm_loader: frames are described at the transaction
// level, expected writes/events are queued, and a monitor checks DUT output.
module tb_wfm_loader;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned OW    = 24;
  localparam int unsigned AW    = 4;

  localparam int EV_DONE  = 1;
  localparam int EV_SHORT = 2;
  localparam int EV_LONG  = 3;
  localparam int EV_LEN   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   load_len;
  logic          s_valid;
  logic          s_ready;
  logic [OW-1:0] s_data;
  logic          s_last;
  logic          wfm_wea;
  logic [AW-1:0] wfm_waddr;
  logic [OW-1:0] wfm_din;
  logic          busy;
  logic          done;
  logic          err_short;
  logic          err_long;
  logic          err_len;
  logic [AW:0]   count;

  int errors = 0;
  int checks = 0;

  int exp_addr[$];
  int exp_data[$];
  int exp_ev[$];

  wfm_loader #(.DEPTH(DEPTH), .OW(OW)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .load_len(load_len), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .wfm_wea(wfm_wea),
    .wfm_waddr(wfm_waddr), .wfm_din(wfm_din), .busy(busy), .done(done),
    .err_short(err_short), .err_long(err_long), .err_len(err_len),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes or pulses an event.
  always @(negedge clk) begin
    int ev;
    int npulse;
    if (!rst) begin
      if (wfm_wea) begin
        if (exp_addr.size() == 0) begin
          check("unexpected_write", 32'(wfm_waddr), 32'hFFFF_FFFF);
        end else begin
          check("write_addr", 32'(wfm_waddr), 32'(exp_addr.pop_front()));
          check("write_data", 32'(wfm_din), 32'(exp_data.pop_front()));
        end
      end
      npulse = int'(done) + int'(err_short) + int'(err_long) + int'(err_len);
      ev = done ? EV_DONE : err_short ? EV_SHORT : err_long ? EV_LONG : err_len ? EV_LEN : 0;
      if (npulse > 1) check("multi_pulse", 32'(npulse), 32'd1);
      if (ev != 0) begin
        if (exp_ev.size() == 0) begin
          check("unexpected_event", 32'(ev), 32'd0);
        end else begin
          check("event_kind", 32'(ev), 32'(exp_ev.pop_front()));
        end
        if (ev != EV_LEN) check("event_with_last_write", 32'(wfm_wea), 32'd1);
      end
    end
  end

  // Present one sample and wait (bounded) for it to be accepted.
  task automatic send_sample(input logic [OW-1:0] d, input bit last, input bit poke);
    bit acc;
    bit seen_ready;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    if (poke) begin
      start    = 1'b1;
      load_len = '0;
    end
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      seen_ready = s_ready;
      @(negedge clk);
      acc = seen_ready;
    end
    start = 1'b0;
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic pulse_start(input int sa, input int len);
    start      = 1'b1;
    start_addr = AW'(sa);
    load_len   = (AW+1)'(len);
    @(negedge clk);
    start = 1'b0;
  endtask

  // One frame of n samples against a programmed length len.
  task automatic run_frame(input int sa, input int len, input int n, input bit seq, input bit poke);
    int d[$];
    int nw;
    nw = (n < len) ? n : len;
    for (int i = 0; i < n; i++) d.push_back(seq ? i + 1 : int'($urandom_range(0, 24'hFFFFFF)));
    for (int i = 0; i < nw; i++) begin
      exp_addr.push_back((sa + i) % DEPTH);
      exp_data.push_back(d[i]);
    end
    exp_ev.push_back((n == len) ? EV_DONE : (n < len) ? EV_SHORT : EV_LONG);
    pulse_start(sa, len);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_sample(OW'(d[i]), i == n - 1, poke && (i == 1));
    end
    repeat (2) @(negedge clk);
    check("busy_after_frame", 32'(busy), 32'd0);
    check("ready_after_frame", 32'(s_ready), 32'd0);
    check("count_after_frame", 32'(count), 32'(nw));
    check("writes_outstanding", 32'(exp_addr.size()), 32'd0);
    check("events_outstanding", 32'(exp_ev.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = '0; load_len = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_wea", 32'(wfm_wea), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulses", 32'({done, err_short, err_long, err_len}), 32'd0);
    check("rst_waddr", 32'(wfm_waddr), 32'd0);
    check("rst_din", 32'(wfm_din), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_frame(0, 16, 16, 1'b1, 1'b0);
    run_frame(14, 4, 4, 1'b0, 1'b0);
    run_frame(int'($urandom_range(0, 15)), 8, 5, 1'b0, 1'b0);
    run_frame(int'($urandom_range(0, 15)), 4, 7, 1'b0, 1'b0);

    // Out-of-range lengths are rejected without arming.
    exp_ev.push_back(EV_LEN);
    pulse_start(3, 0);
    check("busy_len0", 32'(busy), 32'd0);
    exp_ev.push_back(EV_LEN);
    pulse_start(3, 17);
    check("busy_len17", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check("len_events_outstanding", 32'(exp_ev.size()), 32'd0);

    // Reset in the middle of a load.
    pulse_start(5, 8);
    for (int i = 0; i < 3; i++) begin
      exp_addr.push_back((5 + i) % DEPTH);
      exp_data.push_back(100 + i);
      send_sample(OW'(100 + i), 1'b0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_wea", 32'(wfm_wea), 32'd0);
    check("midrst_ready", 32'(s_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_writes_outstanding", 32'(exp_addr.size()), 32'd0);
    run_frame(9, 8, 8, 1'b0, 1'b0);

    for (int f = 0; f < 25; f++) begin
      int len;
      len = int'($urandom_range(1, DEPTH));
      run_frame(int'($urandom_range(0, DEPTH - 1)), len, int'($urandom_range(1, 20)),
                1'b0, ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wfm_loader.md
Name: wfm_loader

Overview:
Waveform-table writer for the dds block. It accepts a frame of samples on a valid/ready stream and drives the dds table write port (wfm_wea/wfm_waddr/wfm_din) from a programmable start address for a programmable length. It checks frame length against the programmed count, flags short and long frames, and reports completion. It sits between a host/config stream source and one dds instance, so tables can be replaced at run time.

Parameters:
DEPTH, 1024, number of entries in the target waveform table; must be a power of 2
OW, 24, sample width; must match the dds output width
AW, $clog2(DEPTH), table address width; derived, not overridden

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle arm pulse; samples start_addr/load_len
start_addr  in  AW  first table address written
load_len  in  AW+1  number of entries to write, 1..DEPTH
s_valid  in  1  stream sample valid
s_ready  out  1  stream ready
s_data  in  OW  stream sample
s_last  in  1  marks final sample of frame
wfm_wea  out  1  table write enable, to dds wfm_wea
wfm_waddr  out  AW  table write address, to dds wfm_waddr
wfm_din  out  OW  table write data, to dds wfm_din
busy  out  1  high in LOAD or DRAIN
done  out  1  one-cycle pulse: frame written with correct length
err_short  out  1  one-cycle pulse: s_last before load_len samples
err_long  out  1  one-cycle pulse: load_len samples accepted without s_last
err_len  out  1  one-cycle pulse: start rejected, load_len out of range
count  out  AW+1  samples written in current/last frame

Behaviour:
- Reset (sync, rst=1 at posedge): state IDLE; s_ready, wfm_wea, busy, done, err_* = 0; wfm_waddr, wfm_din, count = 0. Takes priority over all other inputs, including mid-load; partial table contents are left as-is.
- Handshake: sample accepted on a posedge with s_valid && s_ready. s_valid, s_data and s_last must be held until accepted.
- States:
  - IDLE: s_ready=0. start with 1<=load_len<=DEPTH -> LOAD; latch addr=start_addr, remaining=load_len; count<=0. start with load_len 0 or >DEPTH -> err_len pulse, stay IDLE.
  - LOAD: s_ready=1. Each accepted sample registers wfm_wea=1, wfm_waddr=addr, wfm_din=s_data on the next cycle (1-cycle latency, no bubbles; back-to-back writes at 1/clk). addr increments modulo DEPTH, so it wraps from DEPTH-1 to 0. count increments; remaining decrements.
    - Accept with s_last and remaining==1 -> done pulse, IDLE.
    - Accept with s_last and remaining>1 -> sample is written, err_short pulse, IDLE.
    - Accept without s_last and remaining==1 -> sample is written, err_long pulse, DRAIN.
  - DRAIN: s_ready=1; accepted samples are discarded (no wfm_wea). Accept with s_last -> IDLE.
- done/err_short/err_long pulse on the same cycle as the final wfm_wea, i.e. the cycle after the terminating accept.
- start while busy is ignored; no error is raised.
- wfm_wea is low on every cycle without a write. wfm_waddr and wfm_din hold their last value when idle.
- count holds its final value in IDLE until the next accepted start.
- The block does not coordinate with dds reads. Concurrent reads may see a mix of old and new samples; that is acceptable.

Decomposition:
- The shared dds package holds the state enum (IDLE, LOAD, DRAIN) and the table-address width helper reused by dds.
- No sub-module. The address/length counter is inline.

Test Plan:
- DEPTH=16: start_addr=0, load_len=16, 16 samples 0x000001..0x000010, last on 16th -> 16 writes to addr 0..15 with matching data; done pulses once; count=16; no err.
- start_addr=14, load_len=4, samples A,B,C,D (last on D) -> writes to addr 14,15,0,1; done pulses.
- load_len=8, s_last on 5th sample -> 5 writes; err_short pulses; done stays low; state IDLE; count=5.
- load_len=4, frame of 7 samples (last on 7th) -> exactly 4 writes; err_long pulses after the 4th; samples 5-7 are accepted with s_ready=1 and not written; IDLE afterwards.
- load_len=0, then load_len=17 -> err_len pulses each time; busy stays 0; no writes.
- rst asserted after 3 of 8 samples -> next cycle wfm_wea=0, s_ready=0, busy=0, count=0; a following start with load_len=8 completes normally.
